// File: rtl/nibble_serial_addsub_if.sv
// Handshake and operand/result bundle for the nibble-serial add/sub sequencer.
// The master issues operations. The slave (the sequencer) reports progress and results.
interface nibble_serial_addsub_if #(
  parameter int WIDTH = 16
) ();
  logic             Start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             CarryOut;
  logic             Overflow;

  modport master (
    output Start, Sub, A, B,
    input  Busy, Done, Sum, CarryOut, Overflow
  );

  modport slave (
    input  Start, Sub, A, B,
    output Busy, Done, Sum, CarryOut, Overflow
  );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Wide add/subtract built from one 4-bit slice. Nibbles are processed one per clock,
// least significant first, and the carry ripples through a register between them.
module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_addsub_if.slave bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           stateReg, stateNext;
  logic [WIDTH-1:0] opAReg, opANext;
  logic [WIDTH-1:0] opBReg, opBNext;
  logic             carryReg, carryNext;
  logic [IDXW-1:0]  idxReg, idxNext;
  logic [WIDTH-1:0] resultReg, resultNext;
  logic [WIDTH-1:0] sumReg, sumNext;
  logic             carryOutReg, carryOutNext;
  logic             overflowReg, overflowNext;

  logic [3:0]       aNib [NIB];
  logic [3:0]       bNib [NIB];
  logic [4:0]       sliceOut;
  logic [WIDTH-1:0] assembled;

  // Nibble views of the latched operands, plus the result with the current nibble merged in.
  for (genvar gi = 0; gi < NIB; gi++) begin : gNib
    assign aNib[gi] = opAReg[gi*4 +: 4];
    assign bNib[gi] = opBReg[gi*4 +: 4];
    assign assembled[gi*4 +: 4] = (idxReg == IDXW'(gi)) ? sliceOut[3:0]
                                                          : resultReg[gi*4 +: 4];
  end

  assign sliceOut = {1'b0, aNib[idxReg]} + {1'b0, bNib[idxReg]} + {4'b0000, carryReg};

  always_comb begin
    stateNext    = stateReg;
    opANext      = opAReg;
    opBNext      = opBReg;
    carryNext    = carryReg;
    idxNext      = idxReg;
    resultNext   = resultReg;
    sumNext      = sumReg;
    carryOutNext = carryOutReg;
    overflowNext = overflowReg;

    case (stateReg)
      IDLE, DONE: begin
        if (bus.Start) begin
          // Subtraction is A + ~B + 1, so the inverted B and the seed carry do the work.
          opANext   = bus.A;
          opBNext   = bus.Sub ? ~bus.B : bus.B;
          carryNext = bus.Sub;
          idxNext   = '0;
          stateNext = RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      RUN: begin
        resultNext = assembled;
        carryNext  = sliceOut[4];
        idxNext    = idxReg + 1'b1;
        if (idxReg == LAST_IDX) begin
          sumNext      = assembled;
          carryOutNext = sliceOut[4];
          overflowNext = (opAReg[WIDTH-1] == opBReg[WIDTH-1]) &&
                         (assembled[WIDTH-1] != opAReg[WIDTH-1]);
          stateNext    = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      opAReg      <= '0;
      opBReg      <= '0;
      carryReg    <= 1'b0;
      idxReg      <= '0;
      resultReg   <= '0;
      sumReg      <= '0;
      carryOutReg <= 1'b0;
      overflowReg <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      opAReg      <= opANext;
      opBReg      <= opBNext;
      carryReg    <= carryNext;
      idxReg      <= idxNext;
      resultReg   <= resultNext;
      sumReg      <= sumNext;
      carryOutReg <= carryOutNext;
      overflowReg <= overflowNext;
    end
  end

  assign bus.Busy     = (stateReg == RUN);
  assign bus.Done     = (stateReg == DONE);
  assign bus.Sum      = sumReg;
  assign bus.CarryOut = carryOutReg;
  assign bus.Overflow = overflowReg;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub (WIDTH=16): latency, results, back-to-back
// starts, ignored inputs during RUN, and mid-operation reset.
module tb_nibble_serial_addsub;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passCount  = 0;
  int checkCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge. Issues one operation and follows it to its Done pulse.
  // With junk set, the inputs are scrambled during RUN and Start is left high.
  task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic junk, input logic [15:0] expSum,
                       input logic expC, input logic expOv);
    int edges = 0;
    int busyCycles = 0;
    logic held = 1'b1;
    logic [15:0] prevSum = bus.Sum;
    bus.A = a;
    bus.B = b;
    bus.Sub = sub;
    bus.Start = 1'b1;
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        if (junk) begin
          bus.A = 16'hAAAA;
          bus.B = 16'h5555;
          bus.Sub = ~sub;
        end else begin
          bus.Start = 1'b0;
        end
      end
      if (!bus.Done) begin
        if (bus.Busy) busyCycles++;
        if (bus.Sum !== prevSum) held = 1'b0;
      end
    end while (!bus.Done && edges < 20);
    checkVal({tag, ".edges"}, edges, 5);
    checkVal({tag, ".busyCycles"}, busyCycles, 4);
    checkVal({tag, ".sumHeld"}, {31'b0, held}, 1);
    checkVal({tag, ".sum"}, {16'b0, bus.Sum}, {16'b0, expSum});
    checkVal({tag, ".carry"}, {31'b0, bus.CarryOut}, {31'b0, expC});
    checkVal({tag, ".ovf"}, {31'b0, bus.Overflow}, {31'b0, expOv});
    checkVal({tag, ".busyAtDone"}, {31'b0, bus.Busy}, 0);
    $display("op %s: A=%h B=%h Sub=%0d -> Sum=%h C=%0d V=%0d after %0d edges",
             tag, a, b, sub, bus.Sum, bus.CarryOut, bus.Overflow, edges);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs [5] = '{
    '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1}
  };

  initial begin
    logic doneSeen;
    bus.Start = 1'b0;
    bus.Sub = 1'b0;
    bus.A = '0;
    bus.B = '0;

    repeat (2) @(negedge clk);
    checkVal("rst.busy", {31'b0, bus.Busy}, 0);
    checkVal("rst.done", {31'b0, bus.Done}, 0);
    checkVal("rst.sum", {16'b0, bus.Sum}, 0);
    checkVal("rst.carry", {31'b0, bus.CarryOut}, 0);
    checkVal("rst.ovf", {31'b0, bus.Overflow}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0,
            vecs[i].sum, vecs[i].c, vecs[i].v);
      @(negedge clk);
      checkVal($sformatf("vec%0d.donePulse", i), {31'b0, bus.Done}, 0);
      checkVal($sformatf("vec%0d.sumAfter", i), {16'b0, bus.Sum}, {16'b0, vecs[i].sum});
    end

    // Inputs re-driven during RUN, then a back-to-back start in the DONE cycle.
    runOp("b2b.first", 16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
    runOp("b2b.second", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    @(negedge clk);
    checkVal("b2b.idleDone", {31'b0, bus.Done}, 0);
    checkVal("b2b.idleBusy", {31'b0, bus.Busy}, 0);

    // Reset asserted in the third RUN cycle.
    bus.A = 16'h1111;
    bus.B = 16'h1111;
    bus.Sub = 1'b0;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("abort.busyBefore", {31'b0, bus.Busy}, 1);
    rst_n = 1'b0;
    #1;
    checkVal("abort.busy", {31'b0, bus.Busy}, 0);
    checkVal("abort.done", {31'b0, bus.Done}, 0);
    checkVal("abort.sum", {16'b0, bus.Sum}, 0);
    checkVal("abort.carry", {31'b0, bus.CarryOut}, 0);
    checkVal("abort.ovf", {31'b0, bus.Overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      doneSeen |= bus.Done;
    end
    checkVal("abort.noDone", {31'b0, doneSeen}, 0);
    $display("op abort: reset during RUN, Sum=%h Done seen=%0d", bus.Sum, doneSeen);

    runOp("afterAbort", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
